// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register, stall/branch/flush and HALT control
module fetch_stage #(
    parameter int                     PC_WIDTH    = 8,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [15:0]            NOP_INSTR   = 16'h0000,
    parameter logic [3:0]             HALT_OPCODE = 4'hF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_stall,
    input  logic                i_branch,
    input  logic                i_flush,
    input  logic [PC_WIDTH-1:0] i_branch_target,
    input  logic                i_resume,
    output logic [PC_WIDTH-1:0] o_imem_addr,
    input  logic [15:0]         i_imem_data,
    output logic [15:0]         o_instrD,
    output logic [3:0]          o_opcodeD,
    output logic [PC_WIDTH-1:0] o_pcD,
    output logic                o_validD,
    output logic                o_halted
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [15:0]         r_instr;
    logic [PC_WIDTH-1:0] r_pcD;
    logic                r_valid;
    logic                r_halted;

    logic [PC_WIDTH-1:0] w_pc_inc;
    logic                w_halt_detect;

    // Wraps modulo 2^PC_WIDTH by construction.
    assign w_pc_inc      = r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    assign w_halt_detect = r_valid && (r_instr[15:12] == HALT_OPCODE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_RUN;
            r_pc     <= RESET_PC;
            r_instr  <= NOP_INSTR;
            r_pcD    <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else if (r_state == ST_RUN) begin
            if (i_stall) begin
                r_pc    <= r_pc;
                r_instr <= r_instr;
                r_valid <= r_valid;
            end else if (i_branch) begin
                r_pc    <= i_branch_target;
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end else if (i_flush) begin
                r_pc    <= w_pc_inc;
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end else if (w_halt_detect) begin
                // HALT has now been seen by decode once; freeze PC on the following word.
                r_state  <= ST_HALTED;
                r_halted <= 1'b1;
                r_instr  <= NOP_INSTR;
                r_valid  <= 1'b0;
            end else begin
                r_instr <= i_imem_data;
                r_pcD   <= r_pc;
                r_valid <= 1'b1;
                r_pc    <= w_pc_inc;
            end
        end else begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
            if (i_resume) begin
                r_state  <= ST_RUN;
                r_halted <= 1'b0;
            end
        end
    end

    assign o_imem_addr = r_pc;
    assign o_instrD    = r_instr;
    assign o_opcodeD   = r_instr[15:12];
    assign o_pcD       = r_pcD;
    assign o_validD    = r_valid;
    assign o_halted    = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with reference model
module tb_fetch_stage;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_stall = 1'b0;
    logic        i_branch = 1'b0;
    logic        i_flush = 1'b0;
    logic [7:0]  i_branch_target = 8'h00;
    logic        i_resume = 1'b0;
    logic [7:0]  o_imem_addr;
    logic [15:0] i_imem_data;
    logic [15:0] o_instrD;
    logic [3:0]  o_opcodeD;
    logic [7:0]  o_pcD;
    logic        o_validD;
    logic        o_halted;

    logic [15:0] imem [256];

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0]  m_pc;
    logic [15:0] m_instr;
    logic [7:0]  m_pcD;
    logic        m_valid;
    logic        m_halted;

    fetch_stage dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_stall         (i_stall),
        .i_branch        (i_branch),
        .i_flush         (i_flush),
        .i_branch_target (i_branch_target),
        .i_resume        (i_resume),
        .o_imem_addr     (o_imem_addr),
        .i_imem_data     (i_imem_data),
        .o_instrD        (o_instrD),
        .o_opcodeD       (o_opcodeD),
        .o_pcD           (o_pcD),
        .o_validD        (o_validD),
        .o_halted        (o_halted)
    );

    always #5 i_clk = ~i_clk;

    assign i_imem_data = imem[o_imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_instr = 16'h0000; m_pcD = 8'h00; m_valid = 1'b0; m_halted = 1'b0;
    endtask

    task automatic model_bubble();
        m_instr = 16'h0000;
        m_valid = 1'b0;
    endtask

    // One clock of the fetch rules as stated for the pipeline, applied to the model.
    task automatic model_step();
        if (m_halted) begin
            model_bubble();
            if (i_resume) m_halted = 1'b0;
        end else if (i_stall) begin
        end else if (i_branch) begin
            m_pc = i_branch_target;
            model_bubble();
        end else if (i_flush) begin
            m_pc = m_pc + 8'd1;
            model_bubble();
        end else if (m_valid && m_instr[15:12] == 4'hF) begin
            m_halted = 1'b1;
            model_bubble();
        end else begin
            m_instr = imem[m_pc];
            m_pcD   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 8'd1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"},   32'(o_imem_addr), 32'(m_pc));
        chk({tag, ".instr"},  32'(o_instrD),    32'(m_instr));
        chk({tag, ".opcode"}, 32'(o_opcodeD),   32'(m_instr[15:12]));
        chk({tag, ".valid"},  32'(o_validD),    32'(m_valid));
        chk({tag, ".halted"}, 32'(o_halted),    32'(m_halted));
        if (m_valid) chk({tag, ".pcD"}, 32'(o_pcD), 32'(m_pcD));
    endtask

    task automatic step(input string tag);
        @(posedge i_clk);
        #1;
        model_step();
        check_all(tag);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_stall = 1'b0; i_branch = 1'b0; i_flush = 1'b0; i_resume = 1'b0;
        model_reset();
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) imem[k] = 16'h1000 + 16'(k);
        model_reset();

        // Reset state and free run
        #3;
        check_all("reset");
        chk("reset.pcD", 32'(o_pcD), 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        step("run1");
        chk("run1.instr_const", 32'(o_instrD), 32'h1000);
        chk("run1.pcD_const", 32'(o_pcD), 32'h00);
        step("run2");
        chk("run2.instr_const", 32'(o_instrD), 32'h1001);
        chk("run2.valid_const", 32'(o_validD), 32'h1);
        for (int c = 3; c <= 6; c++) step("run");
        chk("pre_stall.pcD", 32'(o_pcD), 32'h05);

        // Stall three cycles, branch pulse in the middle is ignored
        i_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            i_branch = (c == 1);
            i_branch_target = 8'h99;
            step("stall");
            chk("stall.pcD", 32'(o_pcD), 32'h05);
            chk("stall.instr", 32'(o_instrD), 32'h1005);
            chk("stall.addr", 32'(o_imem_addr), 32'h06);
        end
        i_stall = 1'b0; i_branch = 1'b0;
        step("post_stall");
        chk("post_stall.addr", 32'(o_imem_addr), 32'h07);

        // Taken branch to 0x40 costs one bubble
        i_branch = 1'b1; i_branch_target = 8'h40;
        step("branch");
        i_branch = 1'b0;
        chk("branch.valid", 32'(o_validD), 32'h0);
        chk("branch.addr", 32'(o_imem_addr), 32'h40);
        step("branch_tgt");
        chk("branch_tgt.pcD", 32'(o_pcD), 32'h40);

        // Flush squashes one fetch while PC still advances
        i_flush = 1'b1;
        step("flush");
        i_flush = 1'b0;
        chk("flush.addr", 32'(o_imem_addr), 32'h42);
        step("flush_next");
        chk("flush_next.pcD", 32'(o_pcD), 32'h42);

        // HALT at word 3, hold, resume, halt again at word 8
        imem[3] = 16'hF000;
        imem[8] = 16'hF123;
        do_reset();
        for (int c = 0; c < 4; c++) step("to_halt");
        chk("to_halt.pcD", 32'(o_pcD), 32'h03);
        step("halt");
        chk("halt.halted", 32'(o_halted), 32'h1);
        for (int c = 0; c < 10; c++) begin
            i_branch = (c == 2); i_flush = (c == 4); i_stall = (c == 6);
            i_branch_target = 8'h77;
            step("halted");
            chk("halted.addr", 32'(o_imem_addr), 32'h04);
        end
        i_branch = 1'b0; i_flush = 1'b0; i_stall = 1'b0;
        i_resume = 1'b1;
        step("resume1");
        i_resume = 1'b0;
        chk("resume1.halted", 32'(o_halted), 32'h0);
        step("resume2");
        chk("resume2.pcD", 32'(o_pcD), 32'h04);
        begin
            int budget = 20;
            while (!m_halted && budget > 0) begin
                step("to_halt2");
                budget--;
            end
            chk("halt2.reached", 32'(budget > 0), 32'h1);
        end
        chk("halt2.addr", 32'(o_imem_addr), 32'h09);

        // Asynchronous reset between edges while HALTED
        @(posedge i_clk);
        #3;
        i_rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst.halted", 32'(o_halted), 32'h0);
        chk("async_rst.addr", 32'(o_imem_addr), 32'h00);
        chk("async_rst.valid", 32'(o_validD), 32'h0);
        chk("async_rst.instr", 32'(o_instrD), 32'h0000);
        chk("async_rst.pcD", 32'(o_pcD), 32'h00);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;

        // PC wrap from 0xFE
        i_branch = 1'b1; i_branch_target = 8'hFE;
        step("wrap_br");
        i_branch = 1'b0;
        step("wrap0");
        chk("wrap0.pcD", 32'(o_pcD), 32'hFE);
        step("wrap1");
        chk("wrap1.pcD", 32'(o_pcD), 32'hFF);
        chk("wrap1.addr", 32'(o_imem_addr), 32'h00);
        step("wrap2");
        chk("wrap2.pcD", 32'(o_pcD), 32'h00);

        // Randomized control and memory contents against the model
        for (int k = 0; k < 256; k++) imem[k] = 16'($urandom);
        do_reset();
        for (int c = 0; c < 400; c++) begin
            i_stall  = ($urandom_range(0, 3) == 0);
            i_branch = ($urandom_range(0, 9) == 0);
            i_flush  = ($urandom_range(0, 9) == 0);
            i_resume = ($urandom_range(0, 4) == 0);
            i_branch_target = 8'($urandom);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
